// File: rtl/abc_display_timing_gen_if.sv
// abc_display_timing_gen_if: config registers in, raster timing out.
// ABC_DISPLAY_TEST_PATTERN_EN adds pix_rgb.
interface abc_display_timing_gen_if #(
    parameter int CW  = 12,
    parameter int FCW = 16
);
    logic [31:0] cfg_ctrl, cfg_htiming, cfg_vtiming, cfg_sync;
    logic hsync, vsync, de, frame_start, busy, cfg_err;
    logic [CW-1:0] pix_x, pix_y;
    logic [FCW-1:0] frame_count;
`ifdef ABC_DISPLAY_TEST_PATTERN_EN
    logic [23:0] pix_rgb;
    modport slave (
        input cfg_ctrl, cfg_htiming, cfg_vtiming, cfg_sync,
        output hsync, vsync, de, pix_x, pix_y, frame_start, frame_count, busy, cfg_err, pix_rgb
    );
    modport master (
        output cfg_ctrl, cfg_htiming, cfg_vtiming, cfg_sync,
        input hsync, vsync, de, pix_x, pix_y, frame_start, frame_count, busy, cfg_err, pix_rgb
    );
`else
    modport slave (
        input cfg_ctrl, cfg_htiming, cfg_vtiming, cfg_sync,
        output hsync, vsync, de, pix_x, pix_y, frame_start, frame_count, busy, cfg_err
    );
    modport master (
        output cfg_ctrl, cfg_htiming, cfg_vtiming, cfg_sync,
        input hsync, vsync, de, pix_x, pix_y, frame_start, frame_count, busy, cfg_err
    );
`endif
endinterface

// File: rtl/abc_display_timing_gen.sv
// abc_display_timing_gen: raster timing from config shadowed at frame boundaries.
// Define ABC_DISPLAY_TEST_PATTERN_EN to add the eight-colour-bar pix_rgb output.
module abc_display_timing_gen #(
    parameter int CW  = 12,
    parameter int FCW = 16
) (
    input logic clock,
    input logic reset,
    abc_display_timing_gen_if.slave bus
);
    localparam int SW = CW + 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;
    logic [CW-1:0] h, v, s_ha, s_ht, s_va, s_vt, n_ha, n_ht, n_va, n_vt;
    logic [7:0] s_hfp, s_hsw, s_vfp, s_vsw;
    logic [SW-1:0] hs0, hs1, vs0, vs1;
    logic s_pol, hold, en, single, legal, latch_req, h_last, v_last, eof, de_n, hs_n, vs_n;
    logic unused_cfg;
    assign en = bus.cfg_ctrl[0];
    assign single = bus.cfg_ctrl[2];
    assign n_ha = bus.cfg_htiming[CW-1:0];
    assign n_ht = bus.cfg_htiming[16+CW-1:16];
    assign n_va = bus.cfg_vtiming[CW-1:0];
    assign n_vt = bus.cfg_vtiming[16+CW-1:16];
    assign unused_cfg = ^{bus.cfg_ctrl, bus.cfg_htiming, bus.cfg_vtiming, bus.cfg_sync};
    // sums widened by two bits so an oversized porch+sync can never wrap into a legal value
    assign legal = n_ha != '0 && n_va != '0 && n_ht >= CW'(2) && n_vt != '0
        && SW'(n_ha) + SW'(bus.cfg_sync[7:0]) + SW'(bus.cfg_sync[15:8]) <= SW'(n_ht)
        && SW'(n_va) + SW'(bus.cfg_sync[23:16]) + SW'(bus.cfg_sync[31:24]) <= SW'(n_vt);
    assign h_last = h == s_ht - CW'(1);
    assign v_last = v == s_vt - CW'(1);
    assign eof = h_last && v_last;
    assign latch_req = state == IDLE ? en && !hold : eof && en && !single;
    assign hs0 = SW'(s_ha) + SW'(s_hfp);
    assign hs1 = hs0 + SW'(s_hsw);
    assign vs0 = SW'(s_va) + SW'(s_vfp);
    assign vs1 = vs0 + SW'(s_vsw);
    assign hs_n = SW'(h) >= hs0 && SW'(h) < hs1;
    assign vs_n = SW'(v) >= vs0 && SW'(v) < vs1;
    assign de_n = h < s_ha && v < s_va;

    always_ff @(posedge clock) begin
        if (reset) begin
            {s_ha, s_ht, s_va, s_vt} <= '0;
            {s_hfp, s_hsw, s_vfp, s_vsw} <= '0;
            s_pol <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else if (latch_req) begin
            {s_ha, s_ht, s_va, s_vt} <= {n_ha, n_ht, n_va, n_vt};
            {s_hfp, s_hsw, s_vfp, s_vsw} <= {bus.cfg_sync[7:0], bus.cfg_sync[15:8], bus.cfg_sync[23:16], bus.cfg_sync[31:24]};
            s_pol <= bus.cfg_ctrl[1];
            bus.cfg_err <= !legal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            {h, v} <= '0;
            hold <= 1'b0;
            {bus.hsync, bus.vsync, bus.de, bus.frame_start, bus.busy} <= '0;
            {bus.pix_x, bus.pix_y} <= '0;
            bus.frame_count <= '0;
        end else if (state == IDLE) begin
            {bus.de, bus.frame_start} <= 2'b00;
            {bus.pix_x, bus.pix_y} <= '0;
            {bus.hsync, bus.vsync} <= {s_pol, s_pol};
            {h, v} <= '0;
            // after a single-frame run, wait for enable to drop before starting again
            hold <= hold && en;
            state <= latch_req && legal ? RUN : IDLE;
            bus.busy <= latch_req && legal;
        end else begin
            bus.de <= de_n;
            bus.pix_x <= de_n ? h : '0;
            bus.pix_y <= de_n ? v : '0;
            bus.hsync <= hs_n ^ s_pol;
            bus.vsync <= vs_n ^ s_pol;
            bus.frame_start <= h == '0 && v == '0;
            h <= h_last ? '0 : h + CW'(1);
            if (h_last) v <= v_last ? '0 : v + CW'(1);
            if (!eof) state <= en ? RUN : DRAIN;
            else begin
                bus.frame_count <= bus.frame_count + FCW'(1);
                hold <= en && single;
                state <= latch_req && legal ? RUN : IDLE;
                bus.busy <= latch_req && legal;
            end
        end
    end

`ifdef ABC_DISPLAY_TEST_PATTERN_EN
    logic [CW-1:0] bx, bw;
    logic [3:0] bi;
    assign bw = (s_ha >> 3) == '0 ? CW'(1) : s_ha >> 3;
    // bar index walks with h; index 8 and above are remainder columns (black)
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            bx <= '0;
            bi <= '0;
            bus.pix_rgb <= '0;
        end else begin
            bus.pix_rgb <= de_n && !bi[3] ? {{8{~bi[1]}}, {8{~bi[2]}}, {8{~bi[0] && bi != 4'd7}}} : '0;
            bx <= h_last || bx == bw - CW'(1) ? '0 : bx + CW'(1);
            bi <= h_last ? '0 : bx == bw - CW'(1) ? bi + {3'b000, !bi[3]} : bi;
        end
    end
`endif
endmodule

// File: tb/tb_abc_display_timing_gen.sv
// tb_abc_display_timing_gen: directed test-plan scenarios plus randomized configs,
// checked every cycle against a pixel-index reference model.
module tb_abc_display_timing_gen;
    localparam int CW = 12;
    localparam int FCW = 16;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    abc_display_timing_gen_if #(.CW(CW), .FCW(FCW)) bus ();
    abc_display_timing_gen #(.CW(CW), .FCW(FCW)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0, n_fail = 0;
    int fs_cnt, de_cnt, hs_cnt, vs_cnt;

    // reference model: running flag plus linear pixel index p within the frame
    bit run, hold, err, s_pol;
    int p, fc, s_ha, s_ht, s_hfp, s_hsw, s_va, s_vt, s_vfp, s_vsw;
    bit e_hs, e_vs, e_de, e_fs, e_busy;
    int e_x, e_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic latch();
        s_ha = int'(bus.cfg_htiming[11:0]);
        s_ht = int'(bus.cfg_htiming[27:16]);
        s_va = int'(bus.cfg_vtiming[11:0]);
        s_vt = int'(bus.cfg_vtiming[27:16]);
        s_hfp = int'(bus.cfg_sync[7:0]);
        s_hsw = int'(bus.cfg_sync[15:8]);
        s_vfp = int'(bus.cfg_sync[23:16]);
        s_vsw = int'(bus.cfg_sync[31:24]);
        s_pol = bus.cfg_ctrl[1];
        err = !(s_ha >= 1 && s_va >= 1 && s_ha + s_hfp + s_hsw <= s_ht
                && s_va + s_vfp + s_vsw <= s_vt && s_ht >= 2 && s_vt >= 1);
    endtask

    task automatic model_step();
        bit en, sg;
        int h, v;
        en = bus.cfg_ctrl[0];
        sg = bus.cfg_ctrl[2];
        if (reset) begin
            {run, hold, err, s_pol} = '0;
            {p, fc, s_ha, s_ht, s_hfp, s_hsw, s_va, s_vt, s_vfp, s_vsw} = '0;
            {e_hs, e_vs, e_de, e_fs, e_busy} = '0;
            {e_x, e_y} = '0;
            return;
        end
        if (!run) begin
            {e_de, e_fs} = '0;
            {e_x, e_y} = '0;
            e_hs = s_pol;
            e_vs = s_pol;
            if (en && !hold) begin
                latch();
                run = !err;
                p = 0;
            end
            hold = hold && en;
        end else begin
            h = p % s_ht;
            v = p / s_ht;
            e_de = h < s_ha && v < s_va;
            e_x = e_de ? h : 0;
            e_y = e_de ? v : 0;
            e_fs = p == 0;
            e_hs = (h >= s_ha + s_hfp && h < s_ha + s_hfp + s_hsw) ^ s_pol;
            e_vs = (v >= s_va + s_vfp && v < s_va + s_vfp + s_vsw) ^ s_pol;
            p++;
            if (p == s_ht * s_vt) begin
                p = 0;
                fc = (fc + 1) % (1 << FCW);
                if (!en || sg) begin
                    run = 0;
                    hold = sg && en;
                end else begin
                    latch();
                    run = !err;
                end
            end
        end
        e_busy = run;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("hsync", bus.hsync, e_hs);
        check("vsync", bus.vsync, e_vs);
        check("de", bus.de, e_de);
        check("pix_x", bus.pix_x, e_x);
        check("pix_y", bus.pix_y, e_y);
        check("frame_start", bus.frame_start, e_fs);
        check("busy", bus.busy, e_busy);
        check("cfg_err", bus.cfg_err, err);
        check("frame_count", bus.frame_count, fc);
        fs_cnt += int'(bus.frame_start);
        de_cnt += int'(bus.de);
        hs_cnt += int'(bus.hsync);
        vs_cnt += int'(bus.vsync);
    endtask

    task automatic set_cfg(input int ctrl, ha, hfp, hsw, ht, va, vfp, vsw, vt);
        bus.cfg_ctrl = 32'(ctrl);
        bus.cfg_htiming = (32'(ht) << 16) | 32'(ha);
        bus.cfg_vtiming = (32'(vt) << 16) | 32'(va);
        bus.cfg_sync = (32'(vsw) << 24) | (32'(vfp) << 16) | (32'(hsw) << 8) | 32'(hfp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        {fs_cnt, de_cnt, hs_cnt, vs_cnt} = '0;
    endtask

    task automatic rand_cfg();
        int ha, hfp, hsw, ht, va, vfp, vsw, vt, ctrl;
        ha = $urandom_range(1, 10);
        hfp = $urandom_range(0, 3);
        hsw = $urandom_range(0, 3);
        ht = ha + hfp + hsw + $urandom_range(0, 3);
        if (ht < 2) ht = 2;
        va = $urandom_range(1, 5);
        vfp = $urandom_range(0, 2);
        vsw = $urandom_range(0, 2);
        vt = va + vfp + vsw + $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0) ht = ha + hfp + hsw - 1;
        if ($urandom_range(0, 19) == 0) ha = 0;
        ctrl = int'($urandom_range(0, 6) != 0) | ($urandom_range(0, 1) << 1)
             | (int'($urandom_range(0, 9) == 0) << 2);
        set_cfg(ctrl, ha, hfp, hsw, ht, va, vfp, vsw, vt);
    endtask

    initial begin
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        check("rst_hsync", bus.hsync, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_fc", bus.frame_count, 0);

        // default timing: 16x8 raster, 128-cycle frames
        set_cfg(1, 8, 2, 3, 16, 4, 1, 2, 8);
        cycle();
        cycle();
        check("first_fs", bus.frame_start, 1);
        clear_counts();
        repeat (256) cycle();
        check("fs_per_256", fs_cnt, 2);
        check("de_per_256", de_cnt, 64);
        check("hs_per_256", hs_cnt, 48);
        check("vs_per_256", vs_cnt, 64);

        // illegal then repaired config
        reset = 1'b1;
        set_cfg(1, 8, 6, 4, 16, 4, 1, 2, 8);
        cycle();
        reset = 1'b0;
        clear_counts();
        repeat (5) cycle();
        check("illegal_err", bus.cfg_err, 1);
        check("illegal_busy", bus.busy, 0);
        check("illegal_nosync", hs_cnt + vs_cnt, 0);
        set_cfg(1, 8, 2, 3, 16, 4, 1, 2, 8);
        cycle();
        check("repair_err", bus.cfg_err, 0);
        check("repair_busy", bus.busy, 1);

        // mid-frame h_active change takes effect next frame
        repeat (40) cycle();
        set_cfg(1, 6, 2, 3, 16, 4, 1, 2, 8);
        repeat (300) cycle();

        // enable drops at row 2: frame drains to completion
        set_cfg(1, 8, 2, 3, 16, 4, 1, 2, 8);
        do_reset();
        repeat (34) cycle();
        bus.cfg_ctrl = 32'd0;
        repeat (94) cycle();
        check("drain_busy", bus.busy, 1);
        check("drain_fc0", bus.frame_count, 0);
        cycle();
        check("drain_idle", bus.busy, 0);
        check("drain_fc1", bus.frame_count, 1);
        repeat (10) cycle();

        // single-frame mode
        do_reset();
        bus.cfg_ctrl = 32'd5;
        clear_counts();
        repeat (300) cycle();
        check("single_fs", fs_cnt, 1);
        check("single_fc", bus.frame_count, 1);
        check("single_busy", bus.busy, 0);

        // reset mid-frame with inverted sync polarity
        do_reset();
        bus.cfg_ctrl = 32'd3;
        repeat (50) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_hsync", bus.hsync, 0);
        check("midrst_vsync", bus.vsync, 0);
        check("midrst_fc", bus.frame_count, 0);
        cycle();
        cycle();
        check("restart_fs", bus.frame_start, 1);
        check("restart_x", bus.pix_x, 0);
        repeat (200) cycle();

        // randomized configs, enables and resets
        for (int ep = 0; ep < 40; ep++) begin
            rand_cfg();
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
            end
            repeat ($urandom_range(20, 200)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/abc_display_timing_gen.md
Name: abc_display_timing_gen

Overview:
- Downstream consumer of the four 32-bit configuration registers exposed by the abc_display_ip AXI4-Lite slave (reg0..reg3).
- Turns the register contents into raster timing: hsync, vsync, data-enable, pixel coordinates and frame markers.
- Output drives the pixel pipeline.
- Config is shadowed and applied only at frame boundaries, so AXI writes never tear a frame.

Parameters:
- CW, 12, width of the horizontal/vertical counters and coordinate outputs.
- FCW, 16, width of the frame counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_ctrl  in  32  reg0: [0] enable, [1] sync polarity (1 = active-low), [2] single-frame mode.
- cfg_htiming  in  32  reg1: [11:0] h_active, [27:16] h_total.
- cfg_vtiming  in  32  reg2: [11:0] v_active, [27:16] v_total.
- cfg_sync  in  32  reg3: [7:0] h_fp, [15:8] h_sw, [23:16] v_fp, [31:24] v_sw.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- de  out  1  active-video enable.
- pix_x  out  CW  current column, valid when de=1.
- pix_y  out  CW  current row, valid when de=1.
- frame_start  out  1  one-cycle pulse at h=0, v=0 of every frame.
- frame_count  out  FCW  completed-frame count.
- busy  out  1  1 while in RUN or DRAIN.
- cfg_err  out  1  sticky flag: last latch attempt saw an illegal config.

Behaviour:
Reset values:
- All outputs 0, with hsync and vsync at their inactive level for polarity = 0.
- FSM in IDLE; counters h = v = 0.
- cfg_err = 0, frame_count = 0.

FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - When enable = 1, latch all four inputs into shadow registers and check legality.
  - Legal means: h_active ≥ 1, v_active ≥ 1, h_active+h_fp+h_sw ≤ h_total, v_active+v_fp+v_sw ≤ v_total, h_total ≥ 2, v_total ≥ 1. Sums are computed at CW+2 bits with no wrap.
  - Illegal: cfg_err <= 1 and stay in IDLE. The check is re-attempted every cycle while enable = 1.
  - Legal: cfg_err <= 0, h = v = 0, go to RUN.
- RUN:
  - h increments each cycle. At h = h_total-1, h wraps to 0 and v increments. At v = v_total-1 with h wrap, v wraps to 0.
  - End of frame (last pixel, h = h_total-1, v = v_total-1):
    - frame_count increments; it wraps at 2^FCW.
    - If enable = 0 or single-frame = 1, go to IDLE.
    - Otherwise re-latch the shadow config. A newly illegal config sets cfg_err and goes to IDLE.
- DRAIN: entered from RUN when enable falls mid-frame. Counting continues until end of frame, then IDLE. Re-asserting enable during DRAIN returns to RUN with no disruption.

Output timing:
- All outputs are registered; they reflect counter state with a fixed 1-cycle latency.
- de = (h < h_active) && (v < v_active).
- hsync active when h in [h_active+h_fp, h_active+h_fp+h_sw).
- vsync active when v in [v_active+v_fp, v_active+v_fp+v_sw), for the whole line.
- h_sw = 0 or v_sw = 0 means that sync never asserts.
- Polarity bit inverts hsync and vsync. It is sampled via the shadow registers, so it applies at frame boundaries only.
- pix_x = h and pix_y = v while de = 1; both are held at 0 otherwise.
- frame_start pulses with the first pixel of each frame, including the first frame after IDLE→RUN.

Reset mid-operation: immediate return to the reset state; the frame is abandoned and frame_count is cleared.

Simultaneous events: an input register change in the same cycle as the end-of-frame latch uses the new value.

Optional Feature:
Macro ABC_DISPLAY_TEST_PATTERN_EN.
- Defined: adds output pix_rgb [23:0], registered and aligned with de.
  - Eight vertical colour bars, each floor(h_active/8) pixels wide (minimum 1), in order white, yellow, cyan, green, magenta, red, blue, black. Any remainder columns are black.
  - pix_rgb = 0 when de = 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Default config h_active=8, h_fp=2, h_sw=3, h_total=16; v_active=4, v_fp=1, v_sw=2, v_total=8; enable=1 → de high for 8 of 16 cycles on rows 0-3; hsync high for h=10..12; vsync high for rows 5-6; frame period 128 cycles; frame_start every 128 cycles.
- Illegal config h_active=8, h_fp=6, h_sw=4, h_total=16 → cfg_err=1, busy=0, no syncs. Then write h_fp=2 → RUN starts and cfg_err clears.
- Change h_active to 6 mid-frame → current frame keeps 8-pixel de; the next frame uses 6.
- Drop enable at v=2 → state DRAIN, frame completes to 128 cycles, frame_count +1, then IDLE with busy=0.
- Single-frame=1 → exactly one frame_start pulse, frame_count=1, then IDLE while enable stays 1.
- Assert reset for 1 cycle mid-frame with polarity=1 → all outputs 0 next cycle, frame_count=0; after reset release with enable=1, the frame restarts at h=v=0.
